// File: rtl/i2s_ws_decoder.sv
// I2S word-select framing decoder: synchronizes an external I2S bus, locks onto
// WS transitions and emits right-justified words with framing-error tracking.
module i2s_ws_decoder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_en_i,
    input  logic [4:0]  cfg_data_size_i,
    input  logic [2:0]  cfg_word_num_i,
    input  logic        err_clr_i,
    input  logic        sck_ext_i,
    input  logic        ws_ext_i,
    input  logic        sd_ext_i,
    output logic        locked_o,
    output logic        frame_start_o,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    output logic [2:0]  word_idx_o,
    output logic        err_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SHIFT_W = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

    state_t              state, state_d;
    logic                sck_meta, sck_sync, sck_prev;
    logic                ws_meta, ws_sync, sd_meta, sd_sync;
    logic                ws_last, ws_last_d;
    logic [4:0]          bit_cnt, bit_cnt_d;
    logic [2:0]          word_cnt, word_cnt_d;
    logic [SHIFT_W-1:0]  shift, shift_d;
    logic [DATA_W-1:0]   data_d;
    logic [2:0]          word_idx_d;
    logic                valid_d, fstart_d, err_d, err_set;

    logic                rise_c, ws_change_c, last_bit_c, last_pos_c;
    logic [DATA_W-1:0]   shifted_c, mask_c;

    assign rise_c      = sck_sync & ~sck_prev;
    assign ws_change_c = ws_sync ^ ws_last;
    assign last_bit_c  = (bit_cnt == cfg_data_size_i);
    assign last_pos_c  = last_bit_c && (word_cnt == cfg_word_num_i);
    assign shifted_c   = {shift, sd_sync};
    assign mask_c      = {DATA_W{1'b1}} >> (5'd31 - cfg_data_size_i);

    // Synchronizers and all registered state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            sck_meta      <= 1'b0;
            sck_sync      <= 1'b0;
            sck_prev      <= 1'b0;
            ws_meta       <= 1'b0;
            ws_sync       <= 1'b0;
            sd_meta       <= 1'b0;
            sd_sync       <= 1'b0;
            ws_last       <= 1'b0;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            shift         <= '0;
            locked_o      <= 1'b0;
            frame_start_o <= 1'b0;
            data_o        <= '0;
            data_valid_o  <= 1'b0;
            word_idx_o    <= '0;
            err_o         <= 1'b0;
        end else begin
            state         <= state_d;
            sck_meta      <= sck_ext_i;
            sck_sync      <= sck_meta;
            sck_prev      <= sck_sync;
            ws_meta       <= ws_ext_i;
            ws_sync       <= ws_meta;
            sd_meta       <= sd_ext_i;
            sd_sync       <= sd_meta;
            ws_last       <= ws_last_d;
            bit_cnt       <= bit_cnt_d;
            word_cnt      <= word_cnt_d;
            shift         <= shift_d;
            locked_o      <= (state_d == LOCKED);
            frame_start_o <= fstart_d;
            data_o        <= data_d;
            data_valid_o  <= valid_d;
            word_idx_o    <= word_idx_d;
            err_o         <= err_d;
        end
    end

    // Next-state, counters and output staging.
    always_comb begin
        state_d    = state;
        ws_last_d  = ws_last;
        bit_cnt_d  = bit_cnt;
        word_cnt_d = word_cnt;
        shift_d    = shift;
        data_d     = data_o;
        word_idx_d = word_idx_o;
        valid_d    = 1'b0;
        fstart_d   = 1'b0;
        err_set    = 1'b0;

        if (!cfg_en_i) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = SEARCH;
                end
                SEARCH: begin
                    if (rise_c) begin
                        ws_last_d = ws_sync;
                        if (ws_change_c) begin
                            state_d    = LOCKED;
                            bit_cnt_d  = '0;
                            word_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (rise_c) begin
                        ws_last_d = ws_sync;
                        // WS must toggle exactly at the last bit of the frame.
                        if (ws_change_c != last_pos_c) begin
                            err_set    = 1'b1;
                            state_d    = SEARCH;
                            bit_cnt_d  = '0;
                            word_cnt_d = '0;
                        end else begin
                            shift_d  = shifted_c[SHIFT_W-1:0];
                            fstart_d = (bit_cnt == 5'd0) && (word_cnt == 3'd0);
                            if (last_bit_c) begin
                                data_d     = shifted_c & mask_c;
                                word_idx_d = word_cnt;
                                valid_d    = 1'b1;
                                bit_cnt_d  = '0;
                                word_cnt_d = (word_cnt == cfg_word_num_i) ? 3'd0
                                                                          : 3'(word_cnt + 3'd1);
                            end else begin
                                bit_cnt_d = 5'(bit_cnt + 5'd1);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        err_d = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_o);
    end

endmodule

// File: tb/tb_i2s_ws_decoder.sv
// Self-checking bench for i2s_ws_decoder: drives an I2S bus bit by bit and checks
// against a frame-position reference model.
module tb_i2s_ws_decoder;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_en_i = 1'b1;
    logic [4:0]  cfg_data_size_i = 5'd7;
    logic [2:0]  cfg_word_num_i = 3'd1;
    logic        err_clr_i = 1'b0;
    logic        sck_ext_i = 1'b0;
    logic        ws_ext_i = 1'b0;
    logic        sd_ext_i = 1'b0;
    logic        locked_o, frame_start_o, data_valid_o, err_o;
    logic [31:0] data_o;
    logic [2:0]  word_idx_o;

    always #5 clk = ~clk;

    i2s_ws_decoder dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_en_i(cfg_en_i),
        .cfg_data_size_i(cfg_data_size_i), .cfg_word_num_i(cfg_word_num_i),
        .err_clr_i(err_clr_i), .sck_ext_i(sck_ext_i), .ws_ext_i(ws_ext_i),
        .sd_ext_i(sd_ext_i), .locked_o(locked_o), .frame_start_o(frame_start_o),
        .data_o(data_o), .data_valid_o(data_valid_o), .word_idx_o(word_idx_o),
        .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;
    int sz = 7;
    int nm = 1;
    logic cur_ws = 1'b0;
    logic [31:0] fw [8];

    // Reference model: position within the frame rather than bit/word counters.
    logic        m_locked = 1'b0;
    logic        m_ws_last = 1'b0;
    int          m_pos = 0;
    logic [31:0] m_acc = '0;
    logic        m_err = 1'b0;
    logic [31:0] m_data = '0;
    int          m_fs = 0;
    logic [34:0] exp_q[$];

    logic [34:0] got_q[$];
    int          got_fs = 0;

    always @(negedge clk) begin
        if (data_valid_o) got_q.push_back({word_idx_o, data_o});
        if (frame_start_o) got_fs++;
    end

    initial begin
        #3ms;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_rise(input logic ws, input logic sd);
        int flen;
        logic chg, last;
        flen = (sz + 1) * (nm + 1);
        if (!m_locked) begin
            if (ws !== m_ws_last) begin
                m_locked = 1'b1;
                m_pos = 0;
                m_acc = '0;
            end
        end else begin
            chg  = (ws !== m_ws_last);
            last = (m_pos == flen - 1);
            if (chg != last) begin
                m_err = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_acc = m_acc * 2 + 32'(sd);
                if (m_pos == 0) m_fs++;
                if (m_pos % (sz + 1) == sz) begin
                    exp_q.push_back({3'(m_pos / (sz + 1)), m_acc});
                    m_data = m_acc;
                    m_acc = '0;
                end
                m_pos = (m_pos + 1) % flen;
            end
        end
        m_ws_last = ws;
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_ws_last = 1'b0; m_err = 1'b0; m_data = '0;
    endtask

    task automatic send_bit(input logic ws, input logic sd);
        sck_ext_i = 1'b0;
        ws_ext_i = ws;
        sd_ext_i = sd;
        repeat (4) @(posedge clk);
        #1 sck_ext_i = 1'b1;
        model_rise(ws, sd);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        sck_ext_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic lock_bit();
        send_bit(~cur_ws, 1'b0);
        cur_ws = ~cur_ws;
    endtask

    // One frame from fw[]; err_pos toggles WS early, stuck suppresses the final toggle.
    task automatic send_frame(input int err_pos, input bit stuck, input bit abort);
        int flen;
        logic w;
        flen = (sz + 1) * (nm + 1);
        for (int pos = 0; pos < flen; pos++) begin
            w = cur_ws;
            if (pos == flen - 1 && !stuck) w = ~cur_ws;
            if (pos == err_pos) w = ~cur_ws;
            send_bit(w, fw[pos / (sz + 1)][sz - (pos % (sz + 1))]);
            cur_ws = w;
            checks++;
            if (locked_o !== m_locked) begin
                errors++;
                $display("FAIL locked_bit pos=%0d: got %b expected %b", pos, locked_o, m_locked);
            end
            if (abort && pos == err_pos) return;
        end
    endtask

    task automatic set_cfg(input int s, input int n);
        settle();
        cfg_en_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sz = s; nm = n;
        cfg_data_size_i = 5'(s);
        cfg_word_num_i = 3'(n);
        cfg_en_i = 1'b1;
        m_locked = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({locked_o, frame_start_o, data_valid_o, err_o, data_o, word_idx_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got l=%b fs=%b v=%b e=%b d=%h i=%0d expected all 0",
                     locked_o, frame_start_o, data_valid_o, err_o, data_o, word_idx_o);
        end
        rst_i = 1'b0;
        model_reset();
        settle();
    endtask

    task automatic test_basic();
        int base, fs0;
        base = got_q.size(); fs0 = got_fs;
        lock_bit();
        fw[0] = 32'hA5; fw[1] = 32'h3C;
        send_frame(-1, 0, 0);
        for (int f = 0; f < 2; f++) begin
            fw[0] = $urandom; fw[1] = $urandom;
            send_frame(-1, 0, 0);
        end
        settle();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = base; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_word %0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (got_q[base] !== {3'd0, 32'h0000_00A5} || got_q[base+1] !== {3'd1, 32'h0000_003C}) begin
            errors++;
            $display("FAIL basic_fixed: got %h %h expected 0_000000a5 1_0000003c",
                     got_q[base], got_q[base+1]);
        end
        checks++;
        if (got_fs - fs0 !== 3) begin
            errors++;
            $display("FAIL basic_frame_start: got %0d expected 3", got_fs - fs0);
        end
    endtask

    task automatic test_wide();
        int base;
        set_cfg(31, 0);
        base = got_q.size();
        lock_bit();
        fw[0] = 32'hDEAD_BEEF;
        send_frame(-1, 0, 0);
        fw[0] = $urandom;
        send_frame(-1, 0, 0);
        settle();
        checks++;
        if (got_q.size() - base !== 2 || got_q[base] !== {3'd0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL wide_word: got n=%0d first=%h expected n=2 first=0_deadbeef",
                     got_q.size() - base, got_q[base]);
        end
        checks++;
        if (got_q[base+1] !== exp_q[base+1] || data_o !== m_data) begin
            errors++;
            $display("FAIL wide_second: got %h hold=%h expected %h hold=%h",
                     got_q[base+1], data_o, exp_q[base+1], m_data);
        end
    endtask

    task automatic test_midframe_error();
        set_cfg(7, 1);
        lock_bit();
        fw[0] = $urandom; fw[1] = $urandom;
        send_frame(-1, 0, 0);
        send_frame(8 + 3, 0, 1);
        checks++;
        if (err_o !== 1'b1 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL midframe_err: got err=%b locked=%b expected err=1 locked=0", err_o, locked_o);
        end
        settle();
        checks++;
        if (got_q.size() !== exp_q.size() || data_o !== m_data || word_idx_o !== 3'd0) begin
            errors++;
            $display("FAIL midframe_discard: got n=%0d d=%h i=%0d expected n=%0d d=%h i=0",
                     got_q.size(), data_o, word_idx_o, exp_q.size(), m_data);
        end
        lock_bit();
        send_frame(-1, 0, 0);
        checks++;
        if (locked_o !== 1'b1 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL midframe_relock: got locked=%b err=%b expected 1 1", locked_o, err_o);
        end
        err_clr_i = 1'b1;
        @(posedge clk);
        #1 err_clr_i = 1'b0;
        m_err = 1'b0;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", err_o);
        end
    endtask

    task automatic test_ws_stuck();
        lock_bit();
        fw[0] = $urandom; fw[1] = $urandom;
        send_frame(-1, 0, 0);
        send_frame(-1, 1, 0);
        checks++;
        if (err_o !== 1'b1 || locked_o !== 1'b0 || m_locked !== 1'b0) begin
            errors++;
            $display("FAIL stuck_err: got err=%b locked=%b expected err=1 locked=0", err_o, locked_o);
        end
        lock_bit();
        send_frame(-1, 0, 0);
        settle();
        checks++;
        if (got_q.size() !== exp_q.size() || got_q[$] !== exp_q[$]) begin
            errors++;
            $display("FAIL stuck_words: got n=%0d last=%h expected n=%0d last=%h",
                     got_q.size(), got_q[$], exp_q.size(), exp_q[$]);
        end
    endtask

    task automatic test_reset_midword();
        int n0;
        lock_bit();
        for (int b = 0; b < 3; b++) send_bit(cur_ws, 1'($urandom));
        settle();
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        model_reset();
        checks++;
        if ({locked_o, frame_start_o, data_valid_o, err_o, data_o, word_idx_o} !== '0) begin
            errors++;
            $display("FAIL midword_reset: got l=%b fs=%b v=%b e=%b d=%h i=%0d expected all 0",
                     locked_o, frame_start_o, data_valid_o, err_o, data_o, word_idx_o);
        end
        n0 = got_q.size();
        settle();
        lock_bit();
        fw[0] = $urandom; fw[1] = $urandom;
        send_frame(-1, 0, 0);
        send_frame(-1, 0, 0);
        settle();
        checks++;
        if (got_q.size() !== exp_q.size() || got_q.size() <= n0 || got_q[$] !== exp_q[$]) begin
            errors++;
            $display("FAIL reset_relock: got n=%0d last=%h expected n=%0d last=%h",
                     got_q.size(), got_q[$], exp_q.size(), exp_q[$]);
        end
    endtask

    task automatic test_cfg_disable();
        int n0;
        lock_bit();
        fw[0] = $urandom; fw[1] = $urandom;
        send_frame(-1, 0, 0);
        for (int b = 0; b < 5; b++) send_bit(cur_ws, 1'($urandom));
        n0 = got_q.size();
        sck_ext_i = 1'b0;
        cfg_en_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (locked_o !== 1'b0) begin
            errors++;
            $display("FAIL disable_locked: got %b expected 0", locked_o);
        end
        settle();
        cfg_en_i = 1'b1;
        m_locked = 1'b0;
        settle();
        checks++;
        if (got_q.size() !== n0 || data_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL disable_no_valid: got n=%0d expected %0d", got_q.size(), n0);
        end
        lock_bit();
        send_frame(-1, 0, 0);
        settle();
        checks++;
        if (got_q.size() !== exp_q.size() || got_q[$] !== exp_q[$] || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL disable_relock: got n=%0d last=%h locked=%b expected n=%0d last=%h locked=1",
                     got_q.size(), got_q[$], locked_o, exp_q.size(), exp_q[$]);
        end
    endtask

    task automatic test_random_frames();
        int base;
        for (int it = 0; it < 6; it++) begin
            set_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            base = got_q.size();
            lock_bit();
            for (int f = 0; f < 3; f++) begin
                for (int w = 0; w < 8; w++) fw[w] = $urandom;
                send_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : -1, 0, 0);
            end
            settle();
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rand_count it=%0d: got %0d expected %0d", it, got_q.size(), exp_q.size());
            end else begin
                for (int i = base; i < exp_q.size(); i++) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand_word it=%0d idx=%0d: got %h expected %h", it, i, got_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (got_fs !== m_fs || err_o !== m_err || data_o !== m_data) begin
                errors++;
                $display("FAIL rand_state it=%0d: got fs=%0d err=%b d=%h expected fs=%0d err=%b d=%h",
                         it, got_fs, err_o, data_o, m_fs, m_err, m_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide();
        test_midframe_error();
        test_ws_stuck();
        test_reset_midword();
        test_cfg_disable();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
